mem_wb_pipe: RTL and testbench

Parametrised MEM→WB pipeline register for the Y86 pipeline, successor to the plain MEM/WB latch.
- Carries N write-back channels. Default 2: valE/dstE and valM/dstM.
- Adds status and icode propagation, a valid bit, stall and bubble control, and exception-halt freeze.
- Adds a saturating retired-instruction counter.
- Sits between the memory stage and the register-file write port.
- Drives the write enables and the halt indication seen by the pipeline control logic.

---
 rtl/mem_wb_pipe_pkg.sv | 15 +
 rtl/mem_wb_pipe_sat_counter.sv | 26 ++
 rtl/mem_wb_pipe.sv | 108 ++++++++++
 tb/tb_mem_wb_pipe.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pipe_pkg.sv
// Shared Y86 pipeline constants: status codes, NOP icode, default widths.
package mem_wb_pipe_pkg;

  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_e;

  localparam logic [3:0] INOP       = 4'h1;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_W_DEF  = 4;

endpackage

// File: rtl/mem_wb_pipe_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register with stall/bubble control, halt freeze and retire counter.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_W  = REG_W_DEF,
  parameter int unsigned NCH    = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_valid,
  input  logic [2:0]            m_stat,
  input  logic [3:0]            m_icode,
  input  logic [NCH*DATA_W-1:0] m_val,
  input  logic [NCH*REG_W-1:0]  m_dst,
  input  logic                  w_stall,
  input  logic                  w_bubble,
  output logic                  w_valid,
  output logic [2:0]            w_stat,
  output logic [3:0]            w_icode,
  output logic [NCH*DATA_W-1:0] w_val,
  output logic [NCH*REG_W-1:0]  w_dst,
  output logic [NCH-1:0]        w_wen,
  output logic                  halted,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic                  ctrl_err
);

  logic                  valid_q, valid_d;
  logic [2:0]            stat_q, stat_d;
  logic [3:0]            icode_q, icode_d;
  logic [NCH*DATA_W-1:0] val_q, val_d;
  logic [NCH*REG_W-1:0]  dst_q, dst_d;
  logic                  halted_q, halted_d;
  logic                  err_q, err_d;
  logic                  load;

  // Priority: halted freeze > bubble > stall > load.
  assign load = !halted_q && !w_bubble && !w_stall;

  always_comb begin
    valid_d  = valid_q;
    stat_d   = stat_q;
    icode_d  = icode_q;
    val_d    = val_q;
    dst_d    = dst_q;
    halted_d = halted_q;
    err_d    = err_q;
    if (!halted_q) begin
      if (w_stall && w_bubble) err_d = 1'b1;
      if (w_bubble) begin
        valid_d = 1'b0;
        stat_d  = SAOK;
        icode_d = INOP;
        val_d   = '0;
        dst_d   = '1;
      end else if (!w_stall) begin
        valid_d = m_valid;
        stat_d  = m_stat;
        icode_d = m_icode;
        val_d   = m_val;
        dst_d   = m_dst;
        if (m_valid && (m_stat != SAOK)) halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      stat_q   <= SAOK;
      icode_q  <= INOP;
      val_q    <= '0;
      dst_q    <= '1;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      stat_q   <= stat_d;
      icode_q  <= icode_d;
      val_q    <= val_d;
      dst_q    <= dst_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk_i  (clk),
    .clr_ni (rst),
    .en_i   (load && m_valid),
    .cnt_o  (retire_cnt)
  );

  for (genvar i = 0; i < NCH; i++) begin : g_wen
    assign w_wen[i] = valid_q && (stat_q == SAOK) && (dst_q[i*REG_W +: REG_W] != '1);
  end

  assign w_valid  = valid_q;
  assign w_stat   = stat_q;
  assign w_icode  = icode_q;
  assign w_val    = val_q;
  assign w_dst    = dst_q;
  assign halted   = halted_q;
  assign ctrl_err = err_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed self-checking bench for mem_wb_pipe (default counter and a 4-bit counter instance).
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_val;
  logic [7:0]  m_dst;
  logic        w_stall, w_bubble;

  logic        w_valid, halted, ctrl_err;
  logic [2:0]  w_stat;
  logic [3:0]  w_icode;
  logic [63:0] w_val;
  logic [7:0]  w_dst;
  logic [1:0]  w_wen;
  logic [15:0] retire_cnt;

  logic        s_valid, s_halted, s_err;
  logic [2:0]  s_stat;
  logic [3:0]  s_icode;
  logic [63:0] s_val;
  logic [7:0]  s_dst;
  logic [1:0]  s_wen;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_pipe dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_stat(m_stat), .m_icode(m_icode),
    .m_val(m_val), .m_dst(m_dst), .w_stall(w_stall), .w_bubble(w_bubble),
    .w_valid(w_valid), .w_stat(w_stat), .w_icode(w_icode), .w_val(w_val),
    .w_dst(w_dst), .w_wen(w_wen), .halted(halted), .retire_cnt(retire_cnt),
    .ctrl_err(ctrl_err)
  );

  mem_wb_pipe #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_stat(m_stat), .m_icode(m_icode),
    .m_val(m_val), .m_dst(m_dst), .w_stall(w_stall), .w_bubble(w_bubble),
    .w_valid(s_valid), .w_stat(s_stat), .w_icode(s_icode), .w_val(s_val),
    .w_dst(s_dst), .w_wen(s_wen), .halted(s_halted), .retire_cnt(s_cnt),
    .ctrl_err(s_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] st, input logic [3:0] ic,
                       input logic [63:0] val, input logic [7:0] dst);
    m_valid = v; m_stat = st; m_icode = ic; m_val = val; m_dst = dst;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 64'(w_valid), 64'h0);
    chk({tag, "_stat"}, 64'(w_stat), 64'h1);
    chk({tag, "_icode"}, 64'(w_icode), 64'h1);
    chk({tag, "_val"}, w_val, 64'h0);
    chk({tag, "_dst"}, 64'(w_dst), 64'hFF);
    chk({tag, "_wen"}, 64'(w_wen), 64'h0);
    chk({tag, "_cnt"}, 64'(retire_cnt), 64'h0);
    chk({tag, "_halted"}, 64'(halted), 64'h0);
    chk({tag, "_err"}, 64'(ctrl_err), 64'h0);
  endtask

  initial begin
    rst = 1'b0; w_stall = 1'b0; w_bubble = 1'b0;
    drive(1'b0, 3'd1, 4'h1, 64'h0, 8'hFF);

    // 1. Reset
    step(); step();
    rst = 1'b1;
    chk_reset_state("reset");

    // 2. Load, channel0 = 0x10/dst 0, channel1 = 0x20/dst 3
    drive(1'b1, 3'd1, 4'h6, {32'h20, 32'h10}, {4'h3, 4'h0});
    step();
    chk("load1_val", w_val, {32'h20, 32'h10});
    chk("load1_dst", 64'(w_dst), 64'h30);
    chk("load1_icode", 64'(w_icode), 64'h6);
    chk("load1_wen", 64'(w_wen), 64'h3);
    chk("load1_cnt", 64'(retire_cnt), 64'd1);
    drive(1'b1, 3'd1, 4'h6, {32'h40, 32'h30}, {4'hF, 4'h2});
    step();
    chk("load2_wen", 64'(w_wen), 64'h1);
    chk("load2_cnt", 64'(retire_cnt), 64'd2);

    // 3. Stall with changing inputs
    w_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd1, 4'(i + 7), 64'(i * 3 + 5), 8'(8'h11 * (i + 4)));
      step();
      chk("stall_dst", 64'(w_dst), 64'hF2);
      chk("stall_val", w_val, {32'h40, 32'h30});
      chk("stall_cnt", 64'(retire_cnt), 64'd2);
    end
    w_stall = 1'b0; w_bubble = 1'b1;
    step();
    chk("bubble_icode", 64'(w_icode), 64'h1);
    chk("bubble_dst", 64'(w_dst), 64'hFF);
    chk("bubble_valid", 64'(w_valid), 64'h0);
    chk("bubble_cnt", 64'(retire_cnt), 64'd2);
    chk("bubble_err", 64'(ctrl_err), 64'h0);
    // reload something, then stall+bubble together
    w_bubble = 1'b0;
    drive(1'b1, 3'd1, 4'h2, 64'h55, {4'h4, 4'h4});
    step();
    chk("samedst_wen", 64'(w_wen), 64'h3);
    chk("samedst_cnt", 64'(retire_cnt), 64'd3);
    w_stall = 1'b1; w_bubble = 1'b1;
    step();
    chk("sb_icode", 64'(w_icode), 64'h1);
    chk("sb_dst", 64'(w_dst), 64'hFF);
    chk("sb_val", w_val, 64'h0);
    chk("sb_err", 64'(ctrl_err), 64'h1);
    chk("sb_cnt", 64'(retire_cnt), 64'd3);
    w_stall = 1'b0; w_bubble = 1'b0;
    drive(1'b0, 3'd4, 4'h3, 64'h77, {4'h1, 4'h2});
    step();
    chk("inval_valid", 64'(w_valid), 64'h0);
    chk("inval_wen", 64'(w_wen), 64'h0);
    chk("inval_halted", 64'(halted), 64'h0);
    chk("inval_cnt", 64'(retire_cnt), 64'd3);
    chk("err_sticky", 64'(ctrl_err), 64'h1);

    // 4. HLT
    drive(1'b1, 3'd2, 4'h0, 64'h99, {4'h7, 4'h6});
    step();
    chk("hlt_halted", 64'(halted), 64'h1);
    chk("hlt_wen", 64'(w_wen), 64'h0);
    chk("hlt_cnt", 64'(retire_cnt), 64'd4);
    chk("hlt_stat", 64'(w_stat), 64'h2);
    for (int i = 0; i < 5; i++) begin
      w_bubble = 1'b1; w_stall = 1'(i % 2);
      drive(1'b1, 3'd1, 4'h5, 64'(i + 1), 8'h12);
      step();
      chk("frz_icode", 64'(w_icode), 64'h0);
      chk("frz_dst", 64'(w_dst), 64'h76);
      chk("frz_val", w_val, 64'h99);
      chk("frz_cnt", 64'(retire_cnt), 64'd4);
      chk("frz_halted", 64'(halted), 64'h1);
    end
    rst = 1'b0;
    step();
    rst = 1'b1; w_bubble = 1'b0; w_stall = 1'b0;
    chk_reset_state("rst_after_hlt");

    // 5. ADR exception; stall+bubble while halted must not flag ctrl_err
    drive(1'b1, 3'd3, 4'h5, 64'hAB, {4'h5, 4'h4});
    step();
    chk("adr_halted", 64'(halted), 64'h1);
    chk("adr_wen", 64'(w_wen), 64'h0);
    chk("adr_dst", 64'(w_dst), 64'h54);
    chk("adr_cnt", 64'(retire_cnt), 64'd1);
    w_stall = 1'b1; w_bubble = 1'b1;
    step();
    chk("adr_sb_err", 64'(ctrl_err), 64'h0);
    chk("adr_sb_dst", 64'(w_dst), 64'h54);
    w_stall = 1'b0; w_bubble = 1'b0;

    // 6. Saturation
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'd1, 4'h6, 64'(i), {4'h1, 4'h0});
      step();
    end
    chk("sat_cnt4", 64'(s_cnt), 64'd15);
    chk("sat_cnt16", 64'(retire_cnt), 64'd20);
    chk("sat_halted", 64'(s_halted), 64'h0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("sat_rst_cnt4", 64'(s_cnt), 64'd0);
    chk("sat_rst_cnt16", 64'(retire_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
